// File: rtl/line_serializer.sv
// line_serializer: unloads a captured 128-bit cache line as four 32-bit
// words over a valid/ready beat interface, first word at bits [31:0].
// Optional feature macro: LINE_DIRTY_MASK_EN adds mask_in so that only
// dirty words are emitted, in ascending word order.
module line_serializer (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         load,
   input  logic [127:0] line_in,
   input  logic [31:0]  addr_in,
`ifdef LINE_DIRTY_MASK_EN
   input  logic [3:0]   mask_in,
`endif
   output logic         busy,
   output logic [31:0]  word_out,
   output logic [31:0]  word_addr,
   output logic         word_valid,
   input  logic         word_ready,
   output logic         done
);

   localparam int DATA_W = 32;

   typedef enum logic {IDLE, SEND} state_t;

   state_t              state_q, state_n;
   logic [1:0]          k_q, k_n;
   logic [3:0]          mask_q, mask_n;
   logic [127:0]        line_q;
   logic [27:0]         base_q;
   logic [DATA_W-1:0]   word_n, addr_n;
   logic                valid_n, busy_n, done_n;
   logic [3:0]          load_mask;
   logic                unused_addr_lsbs;

   // The low address nibble addresses bytes within the line and is not needed.
   assign unused_addr_lsbs = ^addr_in[3:0];

`ifdef LINE_DIRTY_MASK_EN
   assign load_mask = mask_in;
`else
   assign load_mask = 4'hF;
`endif

   // Lowest set mask bit at or above 'from'; callers guarantee one exists.
   function automatic logic [1:0] first_at_or_above(input logic [3:0] m, input logic [2:0] from);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (m[i] && (3'(i) >= from)) r = 2'(i);
      end
      return r;
   endfunction

   // Highest set mask bit: the word whose transfer finishes the line.
   function automatic logic [1:0] last_set(input logic [3:0] m);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (m[i]) r = 2'(i);
      end
      return r;
   endfunction

   function automatic logic [DATA_W-1:0] word_sel(input logic [127:0] l, input logic [1:0] k);
      return l[{k, 5'b0} +: DATA_W];
   endfunction

   // Next-state and next-output logic; every output is registered below so
   // word_ready never reaches an output combinationally.
   always_comb begin
      state_n = state_q;
      k_n     = k_q;
      mask_n  = mask_q;
      word_n  = word_out;
      addr_n  = word_addr;
      valid_n = word_valid;
      busy_n  = busy;
      done_n  = 1'b0;
      case (state_q)
         IDLE: begin
            if (load) begin
               mask_n = load_mask;
               if (load_mask != 4'b0000) begin
                  k_n     = first_at_or_above(load_mask, 3'd0);
                  state_n = SEND;
                  valid_n = 1'b1;
                  busy_n  = 1'b1;
                  word_n  = word_sel(line_in, k_n);
                  addr_n  = {addr_in[31:4], k_n, 2'b00};
               end else begin
                  // Nothing dirty: finish immediately without a beat.
                  done_n = 1'b1;
               end
            end
         end
         SEND: begin
            if (word_ready) begin
               if (k_q == last_set(mask_q)) begin
                  state_n = IDLE;
                  valid_n = 1'b0;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
               end else begin
                  k_n    = first_at_or_above(mask_q, {1'b0, k_q} + 3'd1);
                  word_n = word_sel(line_q, k_n);
                  addr_n = {base_q, k_n, 2'b00};
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Control state and registered outputs, cleared by Reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= IDLE;
         k_q        <= 2'd0;
         mask_q     <= 4'd0;
         word_out   <= '0;
         word_addr  <= '0;
         word_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state_q    <= state_n;
         k_q        <= k_n;
         mask_q     <= mask_n;
         word_out   <= word_n;
         word_addr  <= addr_n;
         word_valid <= valid_n;
         busy       <= busy_n;
         done       <= done_n;
      end
   end

   // Line data and base address, written only when a load is accepted.
   always_ff @(posedge Clk) begin
      if (!Reset && state_q == IDLE && load) begin
         line_q <= line_in;
         base_q <= addr_in[31:4];
      end
   end

endmodule

// File: tb/tb_line_serializer.sv
// Self-checking bench for line_serializer with a scoreboard of expected beats.
// Define LINE_DIRTY_MASK_EN for both files to exercise the dirty-mask build.
module tb_line_serializer;

   logic         Clk = 1'b0;
   logic         Reset;
   logic         load;
   logic [127:0] line_in;
   logic [31:0]  addr_in;
`ifdef LINE_DIRTY_MASK_EN
   logic [3:0]   mask_in;
`endif
   logic         busy;
   logic [31:0]  word_out;
   logic [31:0]  word_addr;
   logic         word_valid;
   logic         word_ready;
   logic         done;

   typedef struct packed {
      logic [31:0] d;
      logic [31:0] a;
   } beat_t;

   beat_t exp_q[$];
   beat_t e;
   int    checks = 0;
   int    failures = 0;

   line_serializer dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .load       (load),
      .line_in    (line_in),
      .addr_in    (addr_in),
`ifdef LINE_DIRTY_MASK_EN
      .mask_in    (mask_in),
`endif
      .busy       (busy),
      .word_out   (word_out),
      .word_addr  (word_addr),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .done       (done)
   );

   always #5 Clk = ~Clk;

   // Drive a load for the coming edge and queue the beats it must produce.
   task automatic start_load(input logic [127:0] l, input logic [31:0] a, input logic [3:0] m);
      beat_t b;
      line_in = l;
      addr_in = a;
`ifdef LINE_DIRTY_MASK_EN
      mask_in = m;
`endif
      load = 1'b1;
      for (int k = 0; k < 4; k++) begin
`ifdef LINE_DIRTY_MASK_EN
         if (m[k]) begin
`else
         if (1'b1) begin
`endif
            b.d = l[32*k +: 32];
            b.a = {a[31:4], 2'(k), 2'b00};
            exp_q.push_back(b);
         end
      end
   endtask

   task automatic test_reset;
      Reset = 1'b1;
      load = 1'b0;
      word_ready = 1'b0;
      line_in = '0;
      addr_in = '0;
`ifdef LINE_DIRTY_MASK_EN
      mask_in = 4'hF;
`endif
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         word_ready = ~word_ready;
         checks++;
         if ({busy, word_valid, done, word_out, word_addr} !== 67'd0) begin
            failures++;
            $display("FAIL reset_idle cycle=%0d got busy=%b valid=%b done=%b out=%h addr=%h required all 0",
                     i, busy, word_valid, done, word_out, word_addr);
         end
      end
      word_ready = 1'b0;
   endtask

   task automatic test_full_line;
      word_ready = 1'b1;
      start_load(128'h44444444_33333333_22222222_11111111, 32'h0000_1238, 4'hF);
      for (int c = 1; c <= 8; c++) begin
         @(negedge Clk);
         load = 1'b0;
         if (word_valid && word_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL full_extra_beat c=%0d got %h@%h required no beat", c, word_out, word_addr);
            end else begin
               e = exp_q.pop_front();
               if ({word_out, word_addr} !== {e.d, e.a}) begin
                  failures++;
                  $display("FAIL full_beat c=%0d got %h@%h required %h@%h", c, word_out, word_addr, e.d, e.a);
               end
            end
         end
         checks++;
         if (done !== (c == 5)) begin
            failures++;
            $display("FAIL full_done c=%0d got %b required %b", c, done, (c == 5));
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL full_missing got %0d beats left required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_backpressure;
      start_load(128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001, 32'h8000_0040, 4'hF);
      for (int c = 1; c <= 11; c++) begin
         @(negedge Clk);
         load = (c == 2);
         if (c == 2) begin
            line_in = {4{32'hBAD0BAD0}};
            addr_in = 32'h0000_7770;
         end
         word_ready = (c > 3);
         if (word_valid && !word_ready) begin
            checks++;
            if (exp_q.size() == 0 || {word_out, word_addr} !== {exp_q[0].d, exp_q[0].a}) begin
               failures++;
               $display("FAIL bp_stall c=%0d got %h@%h required first queued beat", c, word_out, word_addr);
            end
         end
         if (word_valid && word_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL bp_extra_beat c=%0d got %h@%h required no beat", c, word_out, word_addr);
            end else begin
               e = exp_q.pop_front();
               if ({word_out, word_addr} !== {e.d, e.a}) begin
                  failures++;
                  $display("FAIL bp_beat c=%0d got %h@%h required %h@%h", c, word_out, word_addr, e.d, e.a);
               end
            end
         end
         checks++;
         if (done !== (c == 8)) begin
            failures++;
            $display("FAIL bp_done c=%0d got %b required %b", c, done, (c == 8));
         end
      end
      checks++;
      if (exp_q.size() != 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL bp_end got left=%0d busy=%b required left=0 busy=0", exp_q.size(), busy);
         exp_q.delete();
      end
   endtask

   task automatic test_back_to_back;
      int nb;
      int nd;
      nb = 0;
      nd = 0;
      word_ready = 1'b1;
      start_load(128'h0A0A0A04_0A0A0A03_0A0A0A02_0A0A0A01, 32'h0000_2000, 4'hF);
      for (int c = 1; c <= 11; c++) begin
         @(negedge Clk);
         load = 1'b0;
         if (c == 5) start_load(128'h0B0B0B04_0B0B0B03_0B0B0B02_0B0B0B01, 32'h0000_3010, 4'hF);
         if (word_valid && word_ready) begin
            if (c <= 10) nb++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL b2b_extra_beat c=%0d got %h@%h required no beat", c, word_out, word_addr);
            end else begin
               e = exp_q.pop_front();
               if ({word_out, word_addr} !== {e.d, e.a}) begin
                  failures++;
                  $display("FAIL b2b_beat c=%0d got %h@%h required %h@%h", c, word_out, word_addr, e.d, e.a);
               end
            end
         end
         if (done === 1'b1 && c <= 10) nd++;
         checks++;
         if (done !== (c == 5 || c == 10)) begin
            failures++;
            $display("FAIL b2b_done c=%0d got %b required %b", c, done, (c == 5 || c == 10));
         end
      end
      checks++;
      if (nb != 8 || nd != 2) begin
         failures++;
         $display("FAIL b2b_counts got beats=%0d dones=%0d required beats=8 dones=2", nb, nd);
      end
      exp_q.delete();
   endtask

   task automatic test_reset_mid_line;
      word_ready = 1'b1;
      start_load(128'h5555_0004_5555_0003_5555_0002_5555_0001, 32'h0000_4000, 4'hF);
      for (int c = 1; c <= 6; c++) begin
         @(negedge Clk);
         load = 1'b0;
         if (c == 1 && word_valid) begin
            e = exp_q.pop_front();
            checks++;
            if ({word_out, word_addr} !== {e.d, e.a}) begin
               failures++;
               $display("FAIL rst_first_beat got %h@%h required %h@%h", word_out, word_addr, e.d, e.a);
            end
         end
         Reset = (c == 2);
         if (c >= 3) begin
            checks++;
            if ({word_valid, busy, done} !== 3'b000) begin
               failures++;
               $display("FAIL rst_abort c=%0d got valid=%b busy=%b done=%b required 000", c, word_valid, busy, done);
            end
         end
      end
      exp_q.delete();
      start_load(128'h6666_0004_6666_0003_6666_0002_6666_0001, 32'h0000_5000, 4'hF);
      for (int c = 1; c <= 6; c++) begin
         @(negedge Clk);
         load = 1'b0;
         if (word_valid && word_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL rst_extra_beat c=%0d got %h@%h required no beat", c, word_out, word_addr);
            end else begin
               e = exp_q.pop_front();
               if ({word_out, word_addr} !== {e.d, e.a}) begin
                  failures++;
                  $display("FAIL rst_restart_beat c=%0d got %h@%h required %h@%h", c, word_out, word_addr, e.d, e.a);
               end
            end
         end
         checks++;
         if (done !== (c == 5)) begin
            failures++;
            $display("FAIL rst_restart_done c=%0d got %b required %b", c, done, (c == 5));
         end
      end
      exp_q.delete();
   endtask

`ifdef LINE_DIRTY_MASK_EN
   task automatic test_dirty_mask;
      word_ready = 1'b1;
      start_load(128'h77770004_77770003_77770002_77770001, 32'h0000_6000, 4'b1010);
      for (int c = 1; c <= 5; c++) begin
         @(negedge Clk);
         load = 1'b0;
         if (word_valid && word_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL mask_extra_beat c=%0d got %h@%h required no beat", c, word_out, word_addr);
            end else begin
               e = exp_q.pop_front();
               if ({word_out, word_addr} !== {e.d, e.a}) begin
                  failures++;
                  $display("FAIL mask_beat c=%0d got %h@%h required %h@%h", c, word_out, word_addr, e.d, e.a);
               end
            end
         end
         checks++;
         if (done !== (c == 3) || busy !== (c <= 2)) begin
            failures++;
            $display("FAIL mask_timing c=%0d got done=%b busy=%b required done=%b busy=%b",
                     c, done, busy, (c == 3), (c <= 2));
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL mask_missing got %0d beats left required 0", exp_q.size());
         exp_q.delete();
      end
      start_load(128'h88880004_88880003_88880002_88880001, 32'h0000_7000, 4'b0000);
      for (int c = 1; c <= 4; c++) begin
         @(negedge Clk);
         load = 1'b0;
         checks++;
         if ({busy, word_valid} !== 2'b00 || done !== (c == 1)) begin
            failures++;
            $display("FAIL mask_empty c=%0d got busy=%b valid=%b done=%b required busy=0 valid=0 done=%b",
                     c, busy, word_valid, done, (c == 1));
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_full_line();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_line();
`ifdef LINE_DIRTY_MASK_EN
      test_dirty_mask();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
